// File: rtl/ic_capture_ctrl.sv
// ic_capture_ctrl: input-capture controller; synchronises ins, qualifies edges by mode/prescaler
// and timestamps each qualifying edge into a first-word-fall-through capture FIFO.
module ic_capture_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [2:0]    icm,
    input  logic [1:0]    ictmr,
    input  logic [1:0]    ici,
    input  logic [TW-1:0] t_val_bi_0,
    input  logic [TW-1:0] t_val_bi_1,
    input  logic          ins,
    input  logic          rd_i,
    output logic [31:0]   icbuf,
    output logic          icbne,
    output logic          icov,
    output logic          ic_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_OFF = 2'd0, S_RUN = 2'd1, S_OVF = 2'd2;

    logic            s1, s2, s3;
    logic [1:0]      state;
    logic [2:0]      icm_q;
    logic [1:0]      ici_q, irq_cnt;
    logic [3:0]      pre;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     cnt;
    logic [31:0]     mem [FIFO_DEPTH];
    logic            rise, fall, active, live, full, evt, pop, push, drop;
    logic [3:0]      pre_last;
    logic [15:0]     t0x, t1x;
    logic [31:0]     stamp;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign active   = en && icm != 3'd0 && icm < 3'd6;
    assign live     = state != S_OFF;
    assign full     = cnt == (AW+1)'(FIFO_DEPTH);
    assign pre_last = icm[0] ? 4'd15 : 4'd3;
    assign t0x      = 16'(t_val_bi_0);
    assign t1x      = 16'(t_val_bi_1);
    assign stamp    = ictmr[1] ? {t1x, t0x} : {16'h0, ictmr[0] ? t1x : t0x};

    always_comb begin
        evt  = (icm == 3'b001) ? (rise | fall) :
               (icm == 3'b010) ? fall :
               (icm == 3'b011) ? rise :
               (icm[2] && !icm[1]) ? (rise && pre == pre_last && icm == icm_q) : 1'b0;
        pop  = live && rd_i && cnt != '0;
        push = live && evt && (!full || pop);
        drop = live && evt && full && !pop;
    end

    assign icbne = cnt != '0;
    assign icbuf = icbne ? mem[rd_ptr] : 32'h0;
    assign icov  = state == S_OVF;

    // Sync chain and config history run regardless of en so re-enabling sees no stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1, s2, s3} <= 3'b000;
            icm_q        <= 3'd0;
            ici_q        <= 2'd0;
        end else begin
            {s1, s2, s3} <= {ins, s1, s2};
            icm_q        <= icm;
            ici_q        <= ici;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_OFF;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            pre     <= 4'd0;
            irq_cnt <= 2'd0;
            ic_irq  <= 1'b0;
        end else if (!active) begin
            state   <= S_OFF;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            pre     <= 4'd0;
            irq_cnt <= 2'd0;
            ic_irq  <= 1'b0;
        end else begin
            state   <= (state == S_OFF) ? S_RUN :
                       drop ? S_OVF :
                       (state == S_OVF && cnt == '0) ? S_RUN : state;
            wr_ptr  <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr  <= pop ? rd_ptr + AW'(1) : rd_ptr;
            cnt     <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            pre     <= (icm != icm_q) ? 4'd0 :
                       (icm[2] && rise) ? ((pre == pre_last) ? 4'd0 : pre + 4'd1) : pre;
            irq_cnt <= (ici != ici_q) ? 2'd0 :
                       push ? ((irq_cnt == ici) ? 2'd0 : irq_cnt + 2'd1) : irq_cnt;
            ic_irq  <= ici == ici_q && push && irq_cnt == ici;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= stamp;
    end
endmodule

// File: tb/tb_ic_capture_ctrl.sv
// tb_ic_capture_ctrl: directed vectors and hand-written sequences for ic_capture_ctrl.
module tb_ic_capture_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, ins = 1'b0, rd_i = 1'b0;
    logic [2:0]  icm = 3'd0;
    logic [1:0]  ictmr = 2'd0, ici = 2'd0;
    logic [15:0] t0 = 16'h0, t1 = 16'h0;
    logic [31:0] icbuf;
    logic        icbne, icov, ic_irq;
    logic        count_t0 = 1'b1;
    int          tests = 0, fails = 0;

    typedef struct {
        logic [1:0]  tmr;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t        vt[4];
    logic [31:0] st[6];
    logic [31:0] e;

    ic_capture_ctrl #(.FIFO_DEPTH(4), .TW(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .icm(icm), .ictmr(ictmr), .ici(ici),
        .t_val_bi_0(t0), .t_val_bi_1(t1), .ins(ins), .rd_i(rd_i),
        .icbuf(icbuf), .icbne(icbne), .icov(icov), .ic_irq(ic_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (count_t0) t0 = t0 + 16'd1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] stamp0();
        return {16'h0, t0 + 16'd2};
    endfunction

    task automatic pop();
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
    endtask

    initial begin
        vt[0] = '{2'b00, 16'h1234, 16'hABCD, 32'h00001234};
        vt[1] = '{2'b01, 16'h1234, 16'hABCD, 32'h0000ABCD};
        vt[2] = '{2'b10, 16'h1234, 16'hABCD, 32'hABCD1234};
        vt[3] = '{2'b11, 16'hFFFF, 16'h0001, 32'h0001FFFF};

        #12;
        chk("rst_icbuf", icbuf, 32'h0);
        chk("rst_icbne", {31'h0, icbne}, 32'h0);
        chk("rst_icov", {31'h0, icov}, 32'h0);
        chk("rst_irq", {31'h0, ic_irq}, 32'h0);
        rst_n = 1'b1;
        en = 1'b1;
        icm = 3'b011;
        tick(2);

        // Rising-edge mode: stamps at t0 = 0x10 and 0x30 land as 0x12 and 0x32.
        t0 = 16'h0010;
        ins = 1'b1;
        tick(3);
        chk("m011_first_buf", icbuf, 32'h00000012);
        chk("m011_first_bne", {31'h0, icbne}, 32'h1);
        ins = 1'b0;
        tick(3);
        chk("m011_fall_ignored_bne", {31'h0, icbne}, 32'h1);
        t0 = 16'h0030;
        ins = 1'b1;
        tick(3);
        chk("m011_head_kept", icbuf, 32'h00000012);
        pop();
        chk("m011_pop1_buf", icbuf, 32'h00000032);
        pop();
        chk("m011_pop2_bne", {31'h0, icbne}, 32'h0);
        chk("m011_pop2_buf", icbuf, 32'h0);
        ins = 1'b0;
        tick(3);

        // Divide-by-4 prescaler: 8 rises give entries at the 4th and 8th.
        icm = 3'b100;
        tick();
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) st[0] = stamp0();
            if (i == 8) st[1] = stamp0();
            ins = 1'b1;
            tick(3);
            ins = 1'b0;
            tick(3);
        end
        chk("pre4_head", icbuf, st[0]);
        pop();
        chk("pre4_second", icbuf, st[1]);
        pop();
        chk("pre4_only_two", {31'h0, icbne}, 32'h0);

        // Every edge, six edges into a 4-deep FIFO: last two dropped.
        icm = 3'b001;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) st[i] = stamp0();
            ins = ~ins;
            tick(3);
        end
        chk("ovf_icov", {31'h0, icov}, 32'h1);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ovf_drain%0d", j), icbuf, st[j]);
            pop();
        end
        chk("ovf_empty_bne", {31'h0, icbne}, 32'h0);
        chk("ovf_still_set", {31'h0, icov}, 32'h1);
        tick();
        chk("ovf_cleared", {31'h0, icov}, 32'h0);

        // Full FIFO, capture coinciding with a pop: both happen, no overflow.
        for (int i = 0; i < 4; i++) begin
            st[i] = stamp0();
            ins = ~ins;
            tick(3);
        end
        ins = ~ins;
        e = stamp0();
        tick(2);
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        chk("fullpop_icov", {31'h0, icov}, 32'h0);
        chk("fullpop_head", icbuf, st[1]);
        st[4] = e;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("fullpop_drain%0d", j), icbuf, st[j]);
            pop();
        end
        chk("fullpop_count4", {31'h0, icbne}, 32'h0);

        // Interrupt every 3rd accepted capture, one cycle wide.
        ici = 2'd2;
        tick();
        for (int i = 1; i <= 7; i++) begin
            ins = ~ins;
            tick(3);
            chk($sformatf("irq_cap%0d", i), {31'h0, ic_irq}, {31'h0, (i == 3 || i == 6)});
            pop();
            chk($sformatf("irq_low%0d", i), {31'h0, ic_irq}, 32'h0);
        end

        // Timestamp source selection.
        count_t0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ictmr = vt[k].tmr;
            t0 = vt[k].a;
            t1 = vt[k].b;
            ins = ~ins;
            tick(3);
            chk($sformatf("tmr%0d_buf", k), icbuf, vt[k].exp);
            pop();
            chk($sformatf("tmr%0d_popped", k), {31'h0, icbne}, 32'h0);
        end

        // en low mid-stream flushes; ins held high across re-enable gives no capture.
        ictmr = 2'b10;
        t0 = 16'h1234;
        t1 = 16'hABCD;
        ins = ~ins;
        tick(3);
        chk("casc_buf", icbuf, 32'hABCD1234);
        ins = ~ins;
        tick(2);
        en = 1'b0;
        tick();
        chk("en0_bne", {31'h0, icbne}, 32'h0);
        chk("en0_buf", icbuf, 32'h0);
        ins = 1'b1;
        tick(4);
        en = 1'b1;
        tick(6);
        chk("reen_no_spurious", {31'h0, icbne}, 32'h0);
        ins = 1'b0;
        tick(3);
        chk("reen_capture", {31'h0, icbne}, 32'h1);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bne", {31'h0, icbne}, 32'h0);
        chk("async_rst_buf", icbuf, 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
